exmem_pipe_reg: RTL and testbench

EXMEM_PIPE_REG -- requirements
Module: exmem_pipe_reg

---
 rtl/exmem_pipe_reg.sv | 166 ++++++++++++++++
 tb/tb_exmem_pipe_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshaking, flush and a stall counter.
// Optional feature macro: EXMEM_SKID_EN adds a second (skid) entry and a registered in_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      EX-side handshake
//   in_* data, in_zero_flag, in_ctrl  EX bundle ({memwrite,memread,branch,j,jmem,stw,regwrite})
//   flush                    kill every held and incoming bundle
//   out_valid / out_ready    MEM-side handshake
//   out_* fields             registered bundle; out_ctrl is zero whenever out_valid=0
//   stall_cnt                saturating count of cycles with out_valid=1 and out_ready=0
module exmem_pipe_reg #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_write_destination,
    input  logic [DATA_W-1:0] in_alu_output,
    input  logic [DATA_W-1:0] in_result_shift_jump,
    input  logic [DATA_W-1:0] in_result_adder_branch,
    input  logic [DATA_W-1:0] in_read_data1,
    input  logic [DATA_W-1:0] in_read_data2,
    input  logic [DATA_W-1:0] in_pc_plus,
    input  logic              in_zero_flag,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_write_destination,
    output logic [DATA_W-1:0] out_alu_output,
    output logic [DATA_W-1:0] out_result_shift_jump,
    output logic [DATA_W-1:0] out_result_adder_branch,
    output logic [DATA_W-1:0] out_read_data1,
    output logic [DATA_W-1:0] out_read_data2,
    output logic [DATA_W-1:0] out_pc_plus,
    output logic              out_zero_flag,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Whole bundle carried as one vector; ctrl occupies the LSBs.
    localparam int unsigned PAY_W = 7 * DATA_W + 1 + CTRL_W;

    logic [PAY_W-1:0] w_in_pay;
    logic [PAY_W-1:0] r_out_pay;
    logic [PAY_W-1:0] w_out_pay_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic             w_in_fire;

    assign w_in_pay = {in_write_destination, in_alu_output, in_result_shift_jump,
                       in_result_adder_branch, in_read_data1, in_read_data2,
                       in_pc_plus, in_zero_flag, in_ctrl};

    assign w_in_fire = in_valid & in_ready;

`ifdef EXMEM_SKID_EN
    logic [PAY_W-1:0] r_skid_pay;
    logic [PAY_W-1:0] w_skid_pay_nxt;
    logic             r_skid_valid;
    logic             w_skid_valid_nxt;
    logic             r_in_ready;

    // Registered readiness; only flush gates it in the current cycle.
    assign in_ready = r_in_ready & ~flush;

    // Output slot refills from skid first to preserve order, then from the input.
    always_comb begin
        w_out_pay_nxt    = r_out_pay;
        w_out_valid_nxt  = r_out_valid;
        w_skid_pay_nxt   = r_skid_pay;
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                w_out_pay_nxt    = r_skid_pay;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_out_pay_nxt   = w_in_pay;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_pay_nxt   = w_in_pay;
            w_skid_valid_nxt = 1'b1;
        end
        // Bubbles must never carry live control bits.
        if (!w_out_valid_nxt) begin
            w_out_pay_nxt[CTRL_W-1:0] = '0;
        end
    end

    // Skid entry and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_pay   <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid_pay   <= w_skid_pay_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end
`else
    // Single entry: accept when empty or draining this cycle.
    assign in_ready = (~r_out_valid | out_ready) & ~flush;

    // Output slot load/drain
    always_comb begin
        w_out_pay_nxt   = r_out_pay;
        w_out_valid_nxt = r_out_valid;
        if (flush) begin
            w_out_valid_nxt = 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (w_in_fire) begin
                w_out_pay_nxt   = w_in_pay;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end
        // Bubbles must never carry live control bits.
        if (!w_out_valid_nxt) begin
            w_out_pay_nxt[CTRL_W-1:0] = '0;
        end
    end
`endif

    // Saturating stall counter
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (r_out_valid && !out_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        end
    end

    // Output register and counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_pay   <= '0;
            r_out_valid <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_out_pay   <= w_out_pay_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign {out_write_destination, out_alu_output, out_result_shift_jump,
            out_result_adder_branch, out_read_data1, out_read_data2,
            out_pc_plus, out_zero_flag, out_ctrl} = r_out_pay;
    assign out_valid = r_out_valid;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg: a queue of in-flight bundles is the reference;
// a second instance with CNT_W=4 exercises counter saturation.
module tb_exmem_pipe_reg;

    localparam int unsigned DW = 20;
    localparam int unsigned CW = 7;
    localparam int unsigned PW = 7 * DW + 1 + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, flush, out_ready;
    logic [DW-1:0] in_write_destination, in_alu_output, in_result_shift_jump;
    logic [DW-1:0] in_result_adder_branch, in_read_data1, in_read_data2, in_pc_plus;
    logic          in_zero_flag;
    logic [CW-1:0] in_ctrl;

    logic          in_ready, out_valid, out_zero_flag;
    logic [DW-1:0] out_write_destination, out_alu_output, out_result_shift_jump;
    logic [DW-1:0] out_result_adder_branch, out_read_data1, out_read_data2, out_pc_plus;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;

    logic          in_ready4, out_valid4, out_zero_flag4;
    logic [DW-1:0] out_write_destination4, out_alu_output4, out_result_shift_jump4;
    logic [DW-1:0] out_result_adder_branch4, out_read_data14, out_read_data24, out_pc_plus4;
    logic [CW-1:0] out_ctrl4;
    logic [3:0]    stall_cnt4;

    exmem_pipe_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_write_destination(in_write_destination), .in_alu_output(in_alu_output),
        .in_result_shift_jump(in_result_shift_jump), .in_result_adder_branch(in_result_adder_branch),
        .in_read_data1(in_read_data1), .in_read_data2(in_read_data2), .in_pc_plus(in_pc_plus),
        .in_zero_flag(in_zero_flag), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_write_destination(out_write_destination), .out_alu_output(out_alu_output),
        .out_result_shift_jump(out_result_shift_jump), .out_result_adder_branch(out_result_adder_branch),
        .out_read_data1(out_read_data1), .out_read_data2(out_read_data2), .out_pc_plus(out_pc_plus),
        .out_zero_flag(out_zero_flag), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    exmem_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_write_destination(in_write_destination), .in_alu_output(in_alu_output),
        .in_result_shift_jump(in_result_shift_jump), .in_result_adder_branch(in_result_adder_branch),
        .in_read_data1(in_read_data1), .in_read_data2(in_read_data2), .in_pc_plus(in_pc_plus),
        .in_zero_flag(in_zero_flag), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_write_destination(out_write_destination4), .out_alu_output(out_alu_output4),
        .out_result_shift_jump(out_result_shift_jump4), .out_result_adder_branch(out_result_adder_branch4),
        .out_read_data1(out_read_data14), .out_read_data2(out_read_data24), .out_pc_plus(out_pc_plus4),
        .out_zero_flag(out_zero_flag4), .out_ctrl(out_ctrl4), .stall_cnt(stall_cnt4)
    );

    // Reference state: bundles accepted but not yet delivered, oldest first.
    logic [PW-1:0] q[$];
    logic [PW-1:0] last_pay;
    int unsigned   exp_cnt, exp_cnt4;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [PW-1:0] pack_in();
        return {in_write_destination, in_alu_output, in_result_shift_jump, in_result_adder_branch,
                in_read_data1, in_read_data2, in_pc_plus, in_zero_flag, in_ctrl};
    endfunction

    function automatic logic exp_ready();
`ifdef EXMEM_SKID_EN
        return (q.size() < 2) && !flush;
`else
        return ((q.size() == 0) || out_ready) && !flush;
`endif
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic rdy, input logic vld,
                             input logic [PW-1:0] pay, input int unsigned cnt,
                             input int unsigned ecnt);
        chk({tag, " in_ready"}, PW'(rdy), PW'(exp_ready()));
        chk({tag, " out_valid"}, PW'(vld), PW'(q.size() != 0));
        if (q.size() != 0) chk({tag, " out_bundle"}, pay, q[0]);
        else chk({tag, " bubble_bundle"}, pay, {last_pay[PW-1:CW], CW'(0)});
        chk({tag, " stall_cnt"}, PW'(cnt), PW'(ecnt));
    endtask

    // Monitor: compare both instances against the reference, then advance it across the next edge.
    always @(negedge clk) begin : monitor
        logic inf, outf;
        check_dut("dut", in_ready, out_valid,
                  {out_write_destination, out_alu_output, out_result_shift_jump, out_result_adder_branch,
                   out_read_data1, out_read_data2, out_pc_plus, out_zero_flag, out_ctrl},
                  int'(stall_cnt), exp_cnt);
        check_dut("dut4", in_ready4, out_valid4,
                  {out_write_destination4, out_alu_output4, out_result_shift_jump4, out_result_adder_branch4,
                   out_read_data14, out_read_data24, out_pc_plus4, out_zero_flag4, out_ctrl4},
                  int'(stall_cnt4), exp_cnt4);
        if (rst) begin
            q.delete();
            exp_cnt  = 0;
            exp_cnt4 = 0;
            last_pay = '0;
        end else begin
            inf  = in_valid && exp_ready();
            outf = (q.size() != 0) && out_ready;
            if ((q.size() != 0) && !out_ready && !flush) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt4 < 15) exp_cnt4++;
            end
            if (flush) q.delete();
            else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(pack_in());
            end
            if (q.size() != 0) last_pay = q[0];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [CW-1:0] ctrl);
        in_valid               = v;
        in_alu_output          = alu;
        in_ctrl                = ctrl;
        in_write_destination   = DW'($urandom);
        in_result_shift_jump   = DW'($urandom);
        in_result_adder_branch = DW'($urandom);
        in_read_data1          = DW'($urandom);
        in_read_data2          = DW'($urandom);
        in_pc_plus             = DW'($urandom);
        in_zero_flag           = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, '0, 7'h7F);
        cyc(2);
        rst = 1'b0;
        drive(1'b0, '0, '0);
        cyc(1);

        // streaming 1,2,3
        out_ready = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            drive(1'b1, DW'(a), CW'($urandom));
            cyc(1);
        end
        drive(1'b0, '0, '0);
        cyc(3);

        // backpressure with A then B
        out_ready = 1'b0;
        drive(1'b1, 20'hAAAAA, 7'h41);
        cyc(1);
        drive(1'b1, 20'h55555, 7'h22);
`ifdef EXMEM_SKID_EN
        cyc(1);
        in_valid = 1'b0;
        cyc(3);
`else
        cyc(3);
        out_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0;
`endif
        out_ready = 1'b1;
        cyc(4);

        // flush with entries held and C presented
        out_ready = 1'b0;
        drive(1'b1, 20'h0D0D0, 7'h11);
        cyc(1);
        drive(1'b1, 20'h0E0E0, 7'h09);
        cyc(1);
        drive(1'b1, 20'hCCCCC, 7'h7F);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        in_valid = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        cyc(3);

        // long stall for counter saturation
        out_ready = 1'b0;
        drive(1'b1, 20'h12345, 7'h05);
        cyc(1);
        in_valid = 1'b0;
        cyc(20);
        out_ready = 1'b1;
        cyc(2);

        // bubbles with live-looking control
        drive(1'b0, '0, 7'h7F);
        repeat (6) begin
            out_ready = 1'($urandom);
            cyc(1);
        end

        // random traffic
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 19) == 0;
            rst       = $urandom_range(0, 99) == 0;
            cyc(1);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(4);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
